// File: rtl/ex_shift_stage_pkg.sv
// Shared widths, opcodes, forwarding codes and FSM encoding for the EX shift stage.
// The 1-bit shift helper is shared by the top's shamt=1 fast path and the iterative datapath.
package ex_shift_stage_pkg;
    localparam int DATA_W  = 8;
    localparam int REG_AW  = 3;
    localparam int SHAMT_W = 3;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_MOV = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_SHIFT = 2'b10;
    localparam logic [1:0] FWD_MOV   = 2'b11;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

    // Logical shift by one with zero fill; right=1 selects SHR.
    function automatic logic [DATA_W-1:0] shift1(input logic [DATA_W-1:0] v, input logic right);
        return right ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
    endfunction
endpackage

// File: rtl/ex_shift_stage_if.sv
// ID/EX inputs, EX/WB outputs and hazard feedback of the EX shift stage.
interface ex_shift_stage_if;
    import ex_shift_stage_pkg::*;
    logic                id_ex_valid;
    logic [1:0]          id_ex_op;
    logic [REG_AW-1:0]   id_ex_rs1;
    logic [REG_AW-1:0]   id_ex_rd;
    logic [SHAMT_W-1:0]  id_ex_shamt;
    logic [DATA_W-1:0]   fwd_data1;
    logic                flush;
    logic [1:0]          fwd_ctrl;
    logic                stall;
    logic                ex_wb_valid;
    logic [1:0]          ex_wb_op;
    logic [REG_AW-1:0]   ex_wb_rd;
    logic [DATA_W-1:0]   ex_wb_data1;
    logic [DATA_W-1:0]   ex_wb_shift_result;

    modport slave (
        input  id_ex_valid, id_ex_op, id_ex_rs1, id_ex_rd, id_ex_shamt, fwd_data1, flush,
        output fwd_ctrl, stall, ex_wb_valid, ex_wb_op, ex_wb_rd, ex_wb_data1, ex_wb_shift_result
    );
    modport master (
        output id_ex_valid, id_ex_op, id_ex_rs1, id_ex_rd, id_ex_shamt, fwd_data1, flush,
        input  fwd_ctrl, stall, ex_wb_valid, ex_wb_op, ex_wb_rd, ex_wb_data1, ex_wb_shift_result
    );
endinterface

// File: rtl/ex_shift_stage_shift_iter.sv
// Iterative 1-bit/cycle shifter: accumulator, remaining count and direction.
// load captures the first (already applied) shift; step applies one more.
module shift_iter
    import ex_shift_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [DATA_W-1:0]  load_acc,
    input  logic [SHAMT_W-1:0] load_cnt,
    input  logic               load_dir,
    output logic [SHAMT_W-1:0] cnt,
    output logic [DATA_W-1:0]  acc_shifted
);
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (load) begin
            acc_d = load_acc;
            cnt_d = load_cnt;
            dir_d = load_dir;
        end else if (step) begin
            acc_d = shift1(acc_q, dir_q);
            cnt_d = cnt_q - SHAMT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            dir_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    assign cnt         = cnt_q;
    assign acc_shifted = shift1(acc_q, dir_q);
endmodule

// File: rtl/ex_shift_stage.sv
// EX stage: single-cycle MOV and short shifts, iterative long shifts with upstream stall,
// EX/WB pipeline register and forwarding control back to the operand mux.
module ex_shift_stage
    import ex_shift_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    ex_shift_stage_if.slave    bus
);
    state_e             state_q, state_d;
    logic               wb_valid_q, wb_valid_d;
    logic [1:0]         wb_op_q, wb_op_d;
    logic [REG_AW-1:0]  wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]  wb_data1_q, wb_data1_d;
    logic [DATA_W-1:0]  wb_shres_q, wb_shres_d;
    logic [REG_AW-1:0]  cap_rd_q, cap_rd_d;
    logic [1:0]         cap_op_q, cap_op_d;

    logic               accept, is_shift, long_shift;
    logic               it_load, it_step;
    logic [SHAMT_W-1:0] it_cnt;
    logic [DATA_W-1:0]  it_acc_shifted, first_shift;

    assign accept      = bus.id_ex_valid & ~bus.flush;
    assign is_shift    = bus.id_ex_op[1];
    assign long_shift  = is_shift & (bus.id_ex_shamt >= SHAMT_W'(2));
    assign first_shift = shift1(bus.fwd_data1, bus.id_ex_op[0]);

    shift_iter u_shift_iter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (it_load),
        .step        (it_step),
        .load_acc    (first_shift),
        .load_cnt    (bus.id_ex_shamt - SHAMT_W'(1)),
        .load_dir    (bus.id_ex_op[0]),
        .cnt         (it_cnt),
        .acc_shifted (it_acc_shifted)
    );

    always_comb begin
        state_d    = state_q;
        wb_valid_d = 1'b0;
        wb_op_d    = wb_op_q;
        wb_rd_d    = wb_rd_q;
        wb_data1_d = wb_data1_q;
        wb_shres_d = wb_shres_q;
        cap_rd_d   = cap_rd_q;
        cap_op_d   = cap_op_q;
        it_load    = 1'b0;
        it_step    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.id_ex_op)
                        OP_MOV: begin
                            wb_valid_d = 1'b1;
                            wb_data1_d = bus.fwd_data1;
                            wb_rd_d    = bus.id_ex_rd;
                            wb_op_d    = bus.id_ex_op;
                        end
                        OP_SHL, OP_SHR: begin
                            if (long_shift) begin
                                it_load  = 1'b1;
                                cap_rd_d = bus.id_ex_rd;
                                cap_op_d = bus.id_ex_op;
                                state_d  = ST_SHIFT;
                            end else begin
                                // shamt 0 passes the operand through, shamt 1 finishes in one shot
                                wb_valid_d = 1'b1;
                                wb_shres_d = (bus.id_ex_shamt == '0) ? bus.fwd_data1 : first_shift;
                                wb_rd_d    = bus.id_ex_rd;
                                wb_op_d    = bus.id_ex_op;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_SHIFT: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (it_cnt > SHAMT_W'(1)) begin
                    it_step = 1'b1;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_shres_d = it_acc_shifted;
                    wb_rd_d    = cap_rd_q;
                    wb_op_d    = cap_op_q;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wb_valid_q <= 1'b0;
            wb_op_q    <= '0;
            wb_rd_q    <= '0;
            wb_data1_q <= '0;
            wb_shres_q <= '0;
            cap_rd_q   <= '0;
            cap_op_q   <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_op_q    <= wb_op_d;
            wb_rd_q    <= wb_rd_d;
            wb_data1_q <= wb_data1_d;
            wb_shres_q <= wb_shres_d;
            cap_rd_q   <= cap_rd_d;
            cap_op_q   <= cap_op_d;
        end
    end

    assign bus.stall = rst_n & (((state_q == ST_IDLE) & accept & long_shift) |
                                ((state_q == ST_SHIFT) & (it_cnt > SHAMT_W'(1)) & ~bus.flush));

    always_comb begin
        bus.fwd_ctrl = FWD_NONE;
        if (rst_n && wb_valid_q && bus.id_ex_valid && (wb_rd_q == bus.id_ex_rs1)) begin
            if (wb_op_q == OP_MOV)   bus.fwd_ctrl = FWD_MOV;
            else if (wb_op_q[1])     bus.fwd_ctrl = FWD_SHIFT;
        end
    end

    assign bus.ex_wb_valid        = wb_valid_q;
    assign bus.ex_wb_op           = wb_op_q;
    assign bus.ex_wb_rd           = wb_rd_q;
    assign bus.ex_wb_data1        = wb_data1_q;
    assign bus.ex_wb_shift_result = wb_shres_q;
endmodule

// File: tb/tb_ex_shift_stage.sv
// Directed bench for ex_shift_stage: expected write-backs are queued at issue time and
// retired by a monitor whenever ex_wb_valid is seen; stall/fwd_ctrl are checked inline.
module tb_ex_shift_stage;
    import ex_shift_stage_pkg::*;

    typedef struct packed {
        logic [1:0]        op;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    ex_shift_stage_if dif();

    ex_shift_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [REG_AW-1:0] rs1,
                         input logic [REG_AW-1:0] rd, input logic [SHAMT_W-1:0] sh,
                         input logic [DATA_W-1:0] d);
        dif.id_ex_valid = v;
        dif.id_ex_op    = op;
        dif.id_ex_rs1   = rs1;
        dif.id_ex_rd    = rd;
        dif.id_ex_shamt = sh;
        dif.fwd_data1   = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Counts stall cycles of the instruction currently held in ID/EX; returns at the
    // negedge of the cycle in which stall drops.
    task automatic count_stall(output int n);
        n = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (!dif.stall) return;
            n++;
            next_cycle();
        end
        checks++;
        failures++;
        $display("FAIL stall_timeout: stall still high after 32 cycles");
    endtask

    // Scoreboard monitor: every cycle with ex_wb_valid high is one new write-back.
    always @(negedge clk) begin
        if (rst_n && dif.ex_wb_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wb: op=%0d rd=%0d", dif.ex_wb_op, dif.ex_wb_rd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_op", dif.ex_wb_op, e.op);
                check("wb_rd", dif.ex_wb_rd, e.rd);
                if (e.op == OP_MOV) check("wb_data1", dif.ex_wb_data1, e.data);
                else                check("wb_shift_result", dif.ex_wb_shift_result, e.data);
            end
        end
    end

    initial begin
        int n;
        drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00);
        dif.flush = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_valid", dif.ex_wb_valid, 0);
        check("rst_data1", dif.ex_wb_data1, 0);
        check("rst_shres", dif.ex_wb_shift_result, 0);
        check("rst_rd", dif.ex_wb_rd, 0);
        check("rst_stall", dif.stall, 0);
        check("rst_fwd", dif.fwd_ctrl, 0);

        // MOV then dependent instruction forwards MOV data
        next_cycle(); rst_n = 1'b1;
        drive(1'b1, OP_MOV, 3'd0, 3'd1, 3'd0, 8'h5A); exp_q.push_back('{OP_MOV, 3'd1, 8'h5A});
        @(negedge clk); check("mov_stall", dif.stall, 0);
        next_cycle();
        drive(1'b1, OP_MOV, 3'd1, 3'd3, 3'd0, 8'h33); exp_q.push_back('{OP_MOV, 3'd3, 8'h33});
        @(negedge clk); check("fwd_mov", dif.fwd_ctrl, 2'b11);

        // SHL 0x81 by 3, rs1 unrelated to EX/WB rd
        next_cycle();
        drive(1'b1, OP_SHL, 3'd7, 3'd2, 3'd3, 8'h81); exp_q.push_back('{OP_SHL, 3'd2, 8'h08});
        count_stall(n); check("shl3_stall_cycles", n, 2);
        next_cycle();
        drive(1'b1, OP_NOP, 3'd2, 3'd0, 3'd0, 8'h00);
        @(negedge clk); check("fwd_shift", dif.fwd_ctrl, 2'b10);
        next_cycle();
        @(negedge clk);
        check("nop_no_wb", dif.ex_wb_valid, 0);
        check("fwd_wb_invalid", dif.fwd_ctrl, 2'b00);

        // shamt 0 and shamt 7
        next_cycle();
        drive(1'b1, OP_SHR, 3'd0, 3'd4, 3'd0, 8'h80); exp_q.push_back('{OP_SHR, 3'd4, 8'h80});
        count_stall(n); check("shr0_stall_cycles", n, 0);
        next_cycle();
        drive(1'b0, OP_MOV, 3'd4, 3'd0, 3'd0, 8'h00);
        @(negedge clk); check("fwd_idex_invalid", dif.fwd_ctrl, 2'b00);
        next_cycle();
        drive(1'b1, OP_SHR, 3'd0, 3'd5, 3'd7, 8'h80); exp_q.push_back('{OP_SHR, 3'd5, 8'h01});
        count_stall(n); check("shr7_stall_cycles", n, 6);
        next_cycle();
        drive(1'b1, OP_SHL, 3'd2, 3'd6, 3'd1, 8'h41); exp_q.push_back('{OP_SHL, 3'd6, 8'h82});
        count_stall(n); check("shl1_stall_cycles", n, 0);
        check("fwd_rs1_mismatch", dif.fwd_ctrl, 2'b00);

        // flush in IDLE kills the MOV
        next_cycle();
        drive(1'b1, OP_MOV, 3'd0, 3'd2, 3'd0, 8'h11); dif.flush = 1'b1;
        @(negedge clk); check("flush_idle_stall", dif.stall, 0);
        next_cycle(); dif.flush = 1'b0;
        drive(1'b1, OP_MOV, 3'd0, 3'd3, 3'd0, 8'hC3); exp_q.push_back('{OP_MOV, 3'd3, 8'hC3});

        // SHL by 5 flushed in its 2nd SHIFT cycle
        next_cycle();
        drive(1'b1, OP_SHL, 3'd0, 3'd6, 3'd5, 8'hFF);
        @(negedge clk); check("shl5_stall_c0", dif.stall, 1);
        next_cycle();
        @(negedge clk); check("shl5_stall_c1", dif.stall, 1);
        next_cycle(); dif.flush = 1'b1;
        @(negedge clk); check("flush_shift_stall", dif.stall, 0);
        next_cycle(); dif.flush = 1'b0;
        drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00);
        @(negedge clk); check("flush_shift_no_wb", dif.ex_wb_valid, 0);
        next_cycle();
        drive(1'b1, OP_MOV, 3'd0, 3'd1, 3'd0, 8'h77); exp_q.push_back('{OP_MOV, 3'd1, 8'h77});
        next_cycle();
        drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00);

        // reset in the middle of a long shift
        next_cycle();
        drive(1'b1, OP_SHL, 3'd1, 3'd7, 3'd6, 8'h01);
        next_cycle();
        next_cycle(); rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", dif.stall, 0);
        check("rst_mid_fwd", dif.fwd_ctrl, 0);
        next_cycle();
        @(negedge clk);
        check("rst_mid_valid", dif.ex_wb_valid, 0);
        check("rst_mid_data1", dif.ex_wb_data1, 0);
        check("rst_mid_shres", dif.ex_wb_shift_result, 0);
        check("rst_mid_rd", dif.ex_wb_rd, 0);
        check("rst_mid_op", dif.ex_wb_op, 0);
        next_cycle(); rst_n = 1'b1;
        drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0, 8'h00);
        repeat (4) next_cycle();
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
